// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW requests into byte-lane writes, queues them in a
// small FIFO, drains them to the data SRAM over req/gnt, and flags load hazards.
module store_buffer #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int ALUOP_W = 8,
    parameter logic [ALUOP_W-1:0] OP_SB = ALUOP_W'(8'h38),
    parameter logic [ALUOP_W-1:0] OP_SH = ALUOP_W'(8'h39),
    parameter logic [ALUOP_W-1:0] OP_SW = ALUOP_W'(8'h3A)
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               st_valid_i,
    input  logic [ALUOP_W-1:0] st_aluop_i,
    input  logic [31:0]        st_addr_i,
    input  logic [31:0]        st_din_i,
    input  logic               flush_i,
    input  logic               ld_valid_i,
    input  logic [31:0]        ld_addr_i,
    output logic               st_stall_o,
    output logic               ld_stall_o,
    output logic               ades_o,
    output logic [31:0]        badvaddr_o,
    output logic               sram_req_o,
    output logic [31:0]        sram_addr_o,
    output logic [3:0]         sram_wen_o,
    output logic [31:0]        sram_wdata_o,
    input  logic               sram_gnt_i,
    output logic               empty_o
);

    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] entry_vld_q, entry_vld_d;
    logic [29:0]      entry_addr_q  [DEPTH];
    logic [29:0]      entry_addr_d  [DEPTH];
    logic [3:0]       entry_wen_q   [DEPTH];
    logic [3:0]       entry_wen_d   [DEPTH];
    logic [31:0]      entry_wdata_q [DEPTH];
    logic [31:0]      entry_wdata_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        is_sb, is_sh, is_sw, misaligned, full, push, pop, ld_hit;
    logic [3:0]  fmt_wen;
    logic [31:0] fmt_wdata;
    logic        ld_lo_unused;

    assign ld_lo_unused = ^ld_addr_i[1:0];

    assign is_sb      = (st_aluop_i == OP_SB);
    assign is_sh      = (st_aluop_i == OP_SH);
    assign is_sw      = (st_aluop_i == OP_SW);
    assign misaligned = (is_sh & st_addr_i[0]) | (is_sw & (st_addr_i[1:0] != 2'b00));
    assign full       = (count_q == CNT_W'(DEPTH));

    assign ades_o     = st_valid_i & ~flush_i & misaligned;
    assign badvaddr_o = ades_o ? st_addr_i : 32'h0;
    assign st_stall_o = st_valid_i & full;

    // A full FIFO refuses the store even if the head is granted this cycle,
    // keeping the stall free of any path from sram_gnt_i.
    assign push = st_valid_i & ~flush_i & ~misaligned & ~full & (is_sb | is_sh | is_sw);
    assign pop  = (count_q != '0) & sram_gnt_i;

    always_comb begin
        fmt_wen   = 4'b0000;
        fmt_wdata = 32'h0;
        if (is_sb) begin
            fmt_wen   = 4'b0001 << st_addr_i[1:0];
            fmt_wdata = {4{st_din_i[7:0]}};
        end else if (is_sh) begin
            fmt_wen   = st_addr_i[1] ? 4'b1100 : 4'b0011;
            fmt_wdata = {2{st_din_i[15:0]}};
        end else if (is_sw) begin
            fmt_wen   = 4'b1111;
            fmt_wdata = st_din_i;
        end
    end

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld_q[i] && (entry_addr_q[i] == ld_addr_i[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign ld_stall_o = ld_valid_i & ld_hit;

    // Head outputs are gated so an empty buffer presents all-zero SRAM signals.
    assign sram_req_o   = (count_q != '0);
    assign sram_addr_o  = sram_req_o ? {entry_addr_q[head_q], 2'b00} : 32'h0;
    assign sram_wen_o   = sram_req_o ? entry_wen_q[head_q] : 4'b0000;
    assign sram_wdata_o = sram_req_o ? entry_wdata_q[head_q] : 32'h0;
    assign empty_o      = (count_q == '0);

    always_comb begin
        entry_vld_d   = entry_vld_q;
        entry_addr_d  = entry_addr_q;
        entry_wen_d   = entry_wen_q;
        entry_wdata_d = entry_wdata_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (pop) begin
            entry_vld_d[head_q] = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end
        if (push) begin
            entry_vld_d[tail_q]   = 1'b1;
            entry_addr_d[tail_q]  = st_addr_i[31:2];
            entry_wen_d[tail_q]   = fmt_wen;
            entry_wdata_d[tail_q] = fmt_wdata;
            tail_d                = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            entry_vld_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr_q[i]  <= '0;
                entry_wen_q[i]   <= '0;
                entry_wdata_q[i] <= '0;
            end
        end else begin
            entry_vld_q   <= entry_vld_d;
            entry_addr_q  <= entry_addr_d;
            entry_wen_q   <= entry_wen_d;
            entry_wdata_q <= entry_wdata_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected SRAM writes are queued as stores are
// driven and compared in order whenever the DUT drains a granted head entry.
module tb_store_buffer;

    localparam logic [7:0] OP_SB  = 8'h38;
    localparam logic [7:0] OP_SH  = 8'h39;
    localparam logic [7:0] OP_SW  = 8'h3A;
    localparam logic [7:0] OP_ADD = 8'h10;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, flush, ld_valid, gnt;
    logic [7:0]  st_aluop;
    logic [31:0] st_addr, st_din, ld_addr;
    logic        st_stall, ld_stall, ades, req, empty;
    logic [31:0] badvaddr, sram_addr, sram_wdata;
    logic [3:0]  sram_wen;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(2), .PTR_W(1), .ALUOP_W(8),
                   .OP_SB(OP_SB), .OP_SH(OP_SH), .OP_SW(OP_SW)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .st_valid_i  (st_valid),
        .st_aluop_i  (st_aluop),
        .st_addr_i   (st_addr),
        .st_din_i    (st_din),
        .flush_i     (flush),
        .ld_valid_i  (ld_valid),
        .ld_addr_i   (ld_addr),
        .st_stall_o  (st_stall),
        .ld_stall_o  (ld_stall),
        .ades_o      (ades),
        .badvaddr_o  (badvaddr),
        .sram_req_o  (req),
        .sram_addr_o (sram_addr),
        .sram_wen_o  (sram_wen),
        .sram_wdata_o(sram_wdata),
        .sram_gnt_i  (gnt),
        .empty_o     (empty)
    );

    function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr,
                                   input logic [31:0] din);
        exp_t e;
        e.addr  = {addr[31:2], 2'b00};
        e.wen   = 4'b0000;
        e.wdata = 32'h0;
        case (op)
            OP_SB: begin
                case (addr[1:0])
                    2'd0: e.wen = 4'b0001;
                    2'd1: e.wen = 4'b0010;
                    2'd2: e.wen = 4'b0100;
                    default: e.wen = 4'b1000;
                endcase
                e.wdata = {din[7:0], din[7:0], din[7:0], din[7:0]};
            end
            OP_SH: begin
                e.wen   = addr[1] ? 4'b1100 : 4'b0011;
                e.wdata = {din[15:0], din[15:0]};
            end
            OP_SW: begin
                e.wen   = 4'b1111;
                e.wdata = din;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] op,
                                 input logic [31:0] addr, input logic [31:0] din,
                                 input logic fl);
        st_valid = valid;
        st_aluop = op;
        st_addr  = addr;
        st_din   = din;
        flush    = fl;
        #1;
    endtask

    task automatic expectStore(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] din);
        exp_q.push_back(model(op, addr, din));
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && empty === 1'b1) break;
            cycle();
        end
        checkOutput(tag, {31'h0, (exp_q.size() == 0 && empty === 1'b1)}, 32'h1);
    endtask

    // Scoreboard: every granted head entry must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && req === 1'b1 && gnt === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_drain", {31'h0, req}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("drain_addr", sram_addr, e.addr);
                checkOutput("drain_wen", {28'h0, sram_wen}, {28'h0, e.wen});
                checkOutput("drain_wdata", sram_wdata, e.wdata);
            end
        end
    end

    initial begin
        rst_n = 1'b0; gnt = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0;
        applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        cycle();
        cycle();
        checkOutput("rst_empty", {31'h0, empty}, 32'h1);
        checkOutput("rst_req", {31'h0, req}, 32'h0);
        checkOutput("rst_wen", {28'h0, sram_wen}, 32'h0);
        checkOutput("rst_stall", {30'h0, st_stall, ld_stall}, 32'h0);
        rst_n = 1'b1;
        cycle();

        $display("[TB] single SW with grant held");
        gnt = 1'b1;
        applyStimulus(1'b1, OP_SW, 32'h8000_0010, 32'h1122_3344, 1'b0);
        expectStore(OP_SW, 32'h8000_0010, 32'h1122_3344);
        checkOutput("t1_stall", {31'h0, st_stall}, 32'h0);
        cycle();
        applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        checkOutput("t1_req", {31'h0, req}, 32'h1);
        checkOutput("t1_addr", sram_addr, 32'h8000_0010);
        checkOutput("t1_wen", {28'h0, sram_wen}, 32'hF);
        checkOutput("t1_wdata", sram_wdata, 32'h1122_3344);
        cycle();
        checkOutput("t1_empty", {31'h0, empty}, 32'h1);

        $display("[TB] SB then SH lane formatting");
        gnt = 1'b0;
        applyStimulus(1'b1, OP_SB, 32'h8000_0013, 32'h0000_00AB, 1'b0);
        expectStore(OP_SB, 32'h8000_0013, 32'h0000_00AB);
        cycle();
        applyStimulus(1'b1, OP_SH, 32'h8000_0002, 32'h0000_BEEF, 1'b0);
        expectStore(OP_SH, 32'h8000_0002, 32'h0000_BEEF);
        cycle();
        applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        checkOutput("t2_head_wen", {28'h0, sram_wen}, 32'h8);
        checkOutput("t2_head_wdata", sram_wdata, 32'hABAB_ABAB);
        gnt = 1'b1;
        waitDrain("t2_drain", 10);

        $display("[TB] full FIFO stall and release");
        gnt = 1'b0;
        applyStimulus(1'b1, OP_SW, 32'h0000_0200, 32'hAAAA_0001, 1'b0);
        expectStore(OP_SW, 32'h0000_0200, 32'hAAAA_0001);
        cycle();
        applyStimulus(1'b1, OP_SW, 32'h0000_0204, 32'hBBBB_0002, 1'b0);
        expectStore(OP_SW, 32'h0000_0204, 32'hBBBB_0002);
        cycle();
        applyStimulus(1'b1, OP_SW, 32'h0000_0208, 32'hCCCC_0003, 1'b0);
        checkOutput("t3_stall_full", {31'h0, st_stall}, 32'h1);
        gnt = 1'b1;
        #1;
        checkOutput("t3_stall_no_gnt_path", {31'h0, st_stall}, 32'h1);
        cycle();
        gnt = 1'b0;
        #1;
        checkOutput("t3_stall_drop", {31'h0, st_stall}, 32'h0);
        expectStore(OP_SW, 32'h0000_0208, 32'hCCCC_0003);
        cycle();
        applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        checkOutput("t3_head_addr", sram_addr, 32'h0000_0204);
        gnt = 1'b1;
        waitDrain("t3_drain", 10);

        $display("[TB] misaligned and non-store requests");
        gnt = 1'b0;
        applyStimulus(1'b1, OP_SH, 32'h8000_0001, 32'h1234_5678, 1'b0);
        checkOutput("t4_sh_ades", {31'h0, ades}, 32'h1);
        checkOutput("t4_sh_badv", badvaddr, 32'h8000_0001);
        cycle();
        checkOutput("t4_sh_empty", {31'h0, empty}, 32'h1);
        applyStimulus(1'b1, OP_SW, 32'h8000_0002, 32'h1234_5678, 1'b0);
        checkOutput("t4_sw_ades", {31'h0, ades}, 32'h1);
        checkOutput("t4_sw_badv", badvaddr, 32'h8000_0002);
        cycle();
        checkOutput("t4_sw_empty", {31'h0, empty}, 32'h1);
        applyStimulus(1'b1, OP_ADD, 32'h8000_0000, 32'h1234_5678, 1'b0);
        cycle();
        checkOutput("t4_nonstore_empty", {31'h0, empty}, 32'h1);
        applyStimulus(1'b1, OP_SB, 32'h8000_0003, 32'h1234_5678, 1'b0);
        checkOutput("t4_sb_ades", {31'h0, ades}, 32'h0);
        checkOutput("t4_sb_badv", badvaddr, 32'h0);
        expectStore(OP_SB, 32'h8000_0003, 32'h1234_5678);
        cycle();
        applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        checkOutput("t4_sb_queued", {31'h0, req}, 32'h1);
        gnt = 1'b1;
        waitDrain("t4_drain", 10);

        $display("[TB] load hazard against pending store");
        gnt = 1'b0;
        applyStimulus(1'b1, OP_SW, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        expectStore(OP_SW, 32'h0000_0100, 32'hDEAD_BEEF);
        cycle();
        applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h0000_0102;
        #1;
        checkOutput("t5_hit", {31'h0, ld_stall}, 32'h1);
        ld_addr = 32'h0000_0104;
        #1;
        checkOutput("t5_miss", {31'h0, ld_stall}, 32'h0);
        ld_addr = 32'h0000_0102;
        gnt = 1'b1;
        #1;
        checkOutput("t5_hit_gnt", {31'h0, ld_stall}, 32'h1);
        cycle();
        gnt = 1'b0;
        #1;
        checkOutput("t5_clear", {31'h0, ld_stall}, 32'h0);
        ld_valid = 1'b0;
        waitDrain("t5_drain", 4);

        $display("[TB] flush and reset with queued stores");
        applyStimulus(1'b1, OP_SW, 32'h0000_0300, 32'h5555_5555, 1'b1);
        cycle();
        checkOutput("t6_flush_empty", {31'h0, empty}, 32'h1);
        applyStimulus(1'b1, OP_SW, 32'h0000_0304, 32'h6666_6666, 1'b0);
        expectStore(OP_SW, 32'h0000_0304, 32'h6666_6666);
        cycle();
        applyStimulus(1'b1, OP_SH, 32'h0000_0308, 32'h0000_7777, 1'b0);
        expectStore(OP_SH, 32'h0000_0308, 32'h0000_7777);
        cycle();
        applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        checkOutput("t6_two_queued", {31'h0, st_stall | req}, 32'h1);
        rst_n = 1'b0;
        cycle();
        exp_q.delete();
        checkOutput("t6_rst_req", {31'h0, req}, 32'h0);
        checkOutput("t6_rst_empty", {31'h0, empty}, 32'h1);
        checkOutput("t6_rst_addr", sram_addr, 32'h0);
        checkOutput("t6_rst_wen", {28'h0, sram_wen}, 32'h0);
        checkOutput("t6_rst_wdata", sram_wdata, 32'h0);
        rst_n = 1'b1;
        cycle();
        checkOutput("t6_post_empty", {31'h0, empty}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
